// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {j,k} commands, pulses them into a JK stage,
// waits a settle window, then checks the stage's q against the expected value.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_op/cmd_ready command
// input; j/k drive to the JK stage; q_fb its q; busy; done_valid/done_q/done_err
// per-command result; err_flag sticky error.
// Optional: define JK_SEQ_ERR_COUNT_EN to add err_count (8-bit saturating).
module jk_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    input  logic       q_fb,
    output logic       busy,
    output logic       done_valid,
    output logic       done_q,
    output logic       done_err,
    output logic       err_flag
`ifdef JK_SEQ_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic          qprev_q, qprev_d;
    logic          j_q, j_d;
    logic          k_q, k_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          dv_q, dv_d;
    logic          dq_q, dq_d;
    logic          derr_q, derr_d;
    logic          eflag_q, eflag_d;
    logic          push;
    logic          pop;
    logic          expected;
    logic          mismatch;
    logic [1:0]    head_op;

    assign head_op = mem_q[rd_ptr_q];
    // ready is registered and equals !full of the current count
    assign push    = cmd_valid & ready_q;

    always_comb begin
        expected = qprev_q;
        unique case (op_q)
            2'b00: expected = qprev_q;
            2'b01: expected = 1'b0;
            2'b10: expected = 1'b1;
            2'b11: expected = ~qprev_q;
            default: expected = qprev_q;
        endcase
    end

    assign mismatch = (q_fb != expected);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        qprev_d = qprev_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        dv_d    = 1'b0;
        dq_d    = dq_q;
        derr_d  = derr_q;
        eflag_d = eflag_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    op_d    = head_op;
                    j_d     = head_op[1];
                    k_d     = head_op[0];
                    qprev_d = q_fb;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d   = SW'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            CHECK: begin
                dv_d    = 1'b1;
                dq_d    = q_fb;
                derr_d  = mismatch;
                eflag_d = eflag_q | mismatch;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ready_d  = (count_d != CW'(FIFO_DEPTH));
        busy_d   = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            qprev_q  <= 1'b0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            dq_q     <= 1'b0;
            derr_q   <= 1'b0;
            eflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            qprev_q  <= qprev_d;
            j_q      <= j_d;
            k_q      <= k_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            dv_q     <= dv_d;
            dq_q     <= dq_d;
            derr_q   <= derr_d;
            eflag_q  <= eflag_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign j          = j_q;
    assign k          = k_q;
    assign busy       = busy_q;
    assign done_valid = dv_q;
    assign done_q     = dq_q;
    assign done_err   = derr_q;
    assign err_flag   = eflag_q;

`ifdef JK_SEQ_ERR_COUNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = ecnt_q;
        if (state_q == CHECK && mismatch && ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ecnt_q <= 8'd0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer with a JK-stage model on q_fb.
// Expected results come from a command-level q model kept in the bench.
module tb_jk_cmd_sequencer;

    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 3 + SETTLE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       busy;
    logic       done_valid;
    logic       done_q;
    logic       done_err;
    logic       err_flag;
`ifdef JK_SEQ_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    jk_cmd_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_ready(cmd_ready),
        .j(j),
        .k(k),
        .q_fb(q_fb),
        .busy(busy),
        .done_valid(done_valid),
        .done_q(done_q),
        .done_err(done_err),
        .err_flag(err_flag)
`ifdef JK_SEQ_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // downstream JK stage; force_zero models a stuck-low q
    logic jk_q = 1'b0;
    logic force_zero = 1'b0;
    always @(posedge clk) begin
        case ({j, k})
            2'b01: jk_q <= 1'b0;
            2'b10: jk_q <= 1'b1;
            2'b11: jk_q <= ~jk_q;
            default: jk_q <= jk_q;
        endcase
    end
    assign q_fb = force_zero ? 1'b0 : jk_q;

    typedef struct {
        logic q;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic ref_q = 1'b0;
    logic exp_flag = 1'b0;
    int   exp_errs = 0;
    logic jk_prev = 1'b0;
    logic spacing_on = 1'b0;
    int   last_done = -1;
    int   n_acc = 0;
    int   low_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic logic apply(logic [1:0] op, logic q);
        case (op)
            2'b00: return q;
            2'b01: return 1'b0;
            2'b10: return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // command-level model: result of each command follows from the previous one
    function automatic void model_accept(logic [1:0] op);
        exp_t e;
        if (force_zero) begin
            e.q   = 1'b0;
            e.err = (apply(op, 1'b0) != 1'b0);
        end else begin
            e.q   = apply(op, ref_q);
            e.err = 1'b0;
        end
        ref_q = apply(op, ref_q);
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            jk_prev = 1'b0;
        end else begin
            if (j | k) chk("jk_single_cycle", int'(jk_prev), 0);
            jk_prev = j | k;
            if (done_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_q", int'(done_q), int'(e.q));
                    chk("done_err", int'(done_err), int'(e.err));
                    exp_flag = exp_flag | e.err;
                    if (e.err && exp_errs < 255) exp_errs++;
                    chk("err_flag", int'(err_flag), int'(exp_flag));
                    if (spacing_on && last_done >= 0)
                        chk("done_spacing", cyc - last_done, PERIOD);
                    last_done = cyc;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!acc && n < 200) begin
            if (!cmd_ready && low_at < 0) low_at = n_acc;
            acc = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) begin
            n_acc++;
            model_accept(op);
        end else begin
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_reached", int'(busy), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        int   seen;
        int   lat;
        logic jk_seen;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_j", int'(j), 0);
        chk("rst_k", int'(k), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_valid", int'(done_valid), 0);
        chk("rst_done_q", int'(done_q), 0);
        chk("rst_done_err", int'(done_err), 0);
        chk("rst_err_flag", int'(err_flag), 0);

        // single set: latency and pulse shape
        send(2'b10);
        cmd_valid = 1'b0;
        lat  = -1;
        seen = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                chk("set_j_pulse", int'(j), 1);
                chk("set_k_pulse", int'(k), 0);
            end
            if (n == 2) chk("set_jk_release", int'(j | k), 0);
            if (done_valid && lat < 0) lat = n;
        end
        chk("set_latency", lat, PERIOD);
        wait_idle();

        // toggle from q=1, then hold
        send(2'b11);
        cmd_valid = 1'b0;
        wait_idle();
        chk("toggle_err_flag", int'(err_flag), 0);
        send(2'b00);
        cmd_valid = 1'b0;
        jk_seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            jk_seen = jk_seen | j | k;
        end
        chk("hold_no_jk", int'(jk_seen), 0);
        wait_idle();

        // burst of DEPTH+2 commands with cmd_valid held
        n_acc      = 0;
        low_at     = -1;
        spacing_on = 1'b1;
        last_done  = -1;
        for (int i = 0; i < DEPTH + 2; i++) send(2'($urandom_range(0, 3)));
        cmd_valid = 1'b0;
        chk("ready_drop_at", low_at, DEPTH + 1);
        wait_idle();
        spacing_on = 1'b0;

        // stuck-low q during a set, then passing commands
        force_zero = 1'b1;
        send(2'b10);
        cmd_valid = 1'b0;
        wait_idle();
        force_zero = 1'b0;
        chk("fault_err_flag", int'(err_flag), 1);
        send(2'b00);
        send(2'b11);
        cmd_valid = 1'b0;
        wait_idle();
        chk("err_flag_sticky", int'(err_flag), 1);
`ifdef JK_SEQ_ERR_COUNT_EN
        chk("err_count", int'(err_count), exp_errs);
`endif

        // reset while a toggle is settling
        send(2'b11);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_flag = 1'b0;
        exp_errs = 0;
        ref_q    = jk_q;
        chk("abort_j", int'(j), 0);
        chk("abort_k", int'(k), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_err_flag", int'(err_flag), 0);
        seen = 0;
        for (int n = 0; n < 3 * PERIOD; n++) begin
            @(posedge clk);
            #1;
            seen = seen + int'(done_valid) + int'(busy);
        end
        chk("abort_quiet", seen, 0);

        // random stream with gaps; exercises push+pop overlap and wrap
        for (int i = 0; i < 24; i++) begin
            send(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
